simple_alu_csr_master: RTL and testbench

Initiator side of the simple ALU CSR request/response interface. It accepts CSR read/write commands from a host-side stream into a small command FIFO, and issues them one at a time on the csr_req channel. It waits for the matching csr_rsp and returns read data, or a timeout error, on a result stream. It sits between the host/core adapter and the ALU CSR manager.

---
 rtl/simple_alu_csr_master.sv | 134 +++++++++++++
 tb/tb_simple_alu_csr_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_alu_csr_master.sv
// CSR request initiator: queues host commands, issues them one at a time
// on csr_req, and returns the response or a timeout error as a result.
module simple_alu_csr_master #(
    parameter int RegCount      = 8,
    parameter int RegDataWidth  = 32,
    parameter int RegAddrWidth  = $clog2(RegCount),
    parameter int CmdDepth      = 4,
    parameter int TimeoutCycles = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [RegAddrWidth-1:0]    cmd_addr_i,
    input  logic [RegDataWidth-1:0]    cmd_wr_data_i,
    input  logic                       cmd_wr_en_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    output logic [RegAddrWidth-1:0]    csr_addr_o,
    output logic [RegDataWidth-1:0]    csr_wr_data_o,
    output logic                       csr_wr_en_o,
    output logic                       csr_req_valid_o,
    input  logic                       csr_req_ready_i,
    input  logic [RegDataWidth-1:0]    csr_rd_data_i,
    input  logic                       csr_rsp_valid_i,
    output logic                       csr_rsp_ready_o,
    output logic [RegDataWidth-1:0]    res_rd_data_o,
    output logic                       res_err_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic                       busy_o,
    output logic [$clog2(CmdDepth+1)-1:0] cmd_count_o
);

    localparam int PtrW = $clog2(CmdDepth);
    localparam int CntW = $clog2(CmdDepth + 1);
    localparam int TmrW = $clog2(TimeoutCycles);
    localparam int EntW = RegAddrWidth + RegDataWidth + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    logic [1:0]      state;
    logic [EntW-1:0] mem [CmdDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic [TmrW-1:0] tmr;
    logic            rsp_rdy;
    logic            full;
    logic            push;
    logic            pop;

    assign full            = (count == CntW'(CmdDepth));
    assign cmd_ready_o     = !full;
    assign push            = cmd_valid_i && cmd_ready_o;
    assign pop             = (state == IDLE) && (count != '0);
    assign csr_req_valid_o = (state == REQ);
    assign csr_rsp_ready_o = rsp_rdy;
    assign busy_o          = (state != IDLE) || (count != '0);
    assign cmd_count_o     = count;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_wr_en_i, cmd_addr_i, cmd_wr_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tmr           <= '0;
            rsp_rdy       <= 1'b0;
            csr_addr_o    <= '0;
            csr_wr_data_o <= '0;
            csr_wr_en_o   <= 1'b0;
            res_rd_data_o <= '0;
            res_err_o     <= 1'b0;
            res_valid_o   <= 1'b0;
        end else begin
            rsp_rdy <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count + CntW'(push) - CntW'(pop);

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        {csr_wr_en_o, csr_addr_o, csr_wr_data_o} <= mem[rd_ptr];
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (csr_req_ready_i) begin
                        tmr   <= '0;
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response on the final cycle still beats the timeout.
                    if (csr_rsp_valid_i) begin
                        res_rd_data_o <= csr_rd_data_i;
                        res_err_o     <= 1'b0;
                        res_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (tmr == TmrW'(TimeoutCycles - 1)) begin
                        res_rd_data_o <= '0;
                        res_err_o     <= 1'b1;
                        res_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tmr <= tmr + TmrW'(1);
                    end
                end
                RESP: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_alu_csr_master.sv
// Directed bench for simple_alu_csr_master with a register-file responder
// that answers one cycle after each accepted request.
module tb_simple_alu_csr_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [2:0]  cmd_addr_i = '0;
    logic [31:0] cmd_wr_data_i = '0;
    logic        cmd_wr_en_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  csr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic        csr_wr_en_o;
    logic        csr_req_valid_o;
    logic        csr_req_ready_i = 1'b0;
    logic [31:0] csr_rd_data_i = '0;
    logic        csr_rsp_valid_i = 1'b0;
    logic        csr_rsp_ready_o;
    logic [31:0] res_rd_data_o;
    logic        res_err_o;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic        busy_o;
    logic [2:0]  cmd_count_o;

    int total = 0;
    int bad = 0;

    bit          auto_rsp = 1'b0;
    bit          stale_req = 1'b0;
    logic [31:0] regs [8];
    logic [31:0] got_data [$];
    bit          got_err [$];
    int          req_seen = 0;

    simple_alu_csr_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wr_data_i(cmd_wr_data_i),
        .cmd_wr_en_i(cmd_wr_en_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .csr_addr_o(csr_addr_o), .csr_wr_data_o(csr_wr_data_o),
        .csr_wr_en_o(csr_wr_en_o), .csr_req_valid_o(csr_req_valid_o),
        .csr_req_ready_i(csr_req_ready_i),
        .csr_rd_data_i(csr_rd_data_i), .csr_rsp_valid_i(csr_rsp_valid_i),
        .csr_rsp_ready_o(csr_rsp_ready_o),
        .res_rd_data_o(res_rd_data_o), .res_err_o(res_err_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .cmd_count_o(cmd_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Responder: returns the old register value, applies writes.
    always @(posedge clk_i) begin
        csr_rsp_valid_i <= 1'b0;
        if (stale_req) begin
            csr_rsp_valid_i <= 1'b1;
            csr_rd_data_i   <= 32'hBAD0BAD0;
        end else if (auto_rsp && csr_req_valid_o && csr_req_ready_i) begin
            csr_rsp_valid_i <= 1'b1;
            csr_rd_data_i   <= regs[csr_addr_o];
            if (csr_wr_en_o) regs[csr_addr_o] <= csr_wr_data_o;
        end
    end

    // Handshakes complete at the next posedge; inputs only change at #1.
    always @(negedge clk_i) begin
        if (!rst_i && res_valid_o && res_ready_i) begin
            got_data.push_back(res_rd_data_o);
            got_err.push_back(res_err_o);
        end
        if (!rst_i && csr_req_valid_o && csr_req_ready_i) req_seen++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] a, input logic [31:0] d,
                            input logic we);
        int n = 0;
        cmd_addr_i = a;
        cmd_wr_data_i = d;
        cmd_wr_en_i = we;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 200) begin
            step();
            n++;
        end
        if (!cmd_ready_o) begin
            total++; bad++;
            $display("FAIL push_timeout addr=%0d", a);
        end
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_results(input int k);
        int n = 0;
        while (got_data.size() < k && n < 500) begin
            step();
            n++;
        end
        if (got_data.size() < k) begin
            total++; bad++;
            $display("FAIL wait_results got=%0d want=%0d", got_data.size(), k);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        total++;
        if ({csr_req_valid_o, res_valid_o, res_err_o, busy_o, csr_wr_en_o} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000",
                {csr_req_valid_o, res_valid_o, res_err_o, busy_o, csr_wr_en_o});
        end
        total++;
        if (cmd_ready_o !== 1'b1 || cmd_count_o !== 3'd0) begin
            bad++; $display("FAIL reset_fifo ready=%b count=%0d want 1/0",
                cmd_ready_o, cmd_count_o);
        end
        total++;
        if (res_rd_data_o !== 32'h0 || csr_wr_data_o !== 32'h0 || csr_addr_o !== 3'd0) begin
            bad++; $display("FAIL reset_data res=%h wr=%h addr=%0d want 0",
                res_rd_data_o, csr_wr_data_o, csr_addr_o);
        end
        rst_i = 1'b0;
        step();
        total++;
        if (csr_rsp_ready_o !== 1'b1) begin
            bad++; $display("FAIL rsp_ready got=%b want=1", csr_rsp_ready_o);
        end
    endtask

    task automatic test_single_write();
        auto_rsp = 1'b1;
        csr_req_ready_i = 1'b1;
        res_ready_i = 1'b1;
        got_data.delete(); got_err.delete();
        push_cmd(3'd0, 32'h3, 1'b1);
        total++;
        if (cmd_count_o !== 3'd1 || csr_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL sw_push count=%0d req=%b busy=%b want 1/0/1",
                cmd_count_o, csr_req_valid_o, busy_o);
        end
        step();
        total++;
        if (csr_req_valid_o !== 1'b1 || csr_addr_o !== 3'd0 ||
            csr_wr_data_o !== 32'h3 || csr_wr_en_o !== 1'b1) begin
            bad++; $display("FAIL sw_req valid=%b addr=%0d data=%h we=%b want 1/0/3/1",
                csr_req_valid_o, csr_addr_o, csr_wr_data_o, csr_wr_en_o);
        end
        step();
        total++;
        if (csr_req_valid_o !== 1'b0 || res_valid_o !== 1'b0) begin
            bad++; $display("FAIL sw_wait req=%b res=%b want 0/0",
                csr_req_valid_o, res_valid_o);
        end
        step();
        total++;
        if (res_valid_o !== 1'b1 || res_err_o !== 1'b0 || res_rd_data_o !== 32'h0) begin
            bad++; $display("FAIL sw_res valid=%b err=%b data=%h want 1/0/0",
                res_valid_o, res_err_o, res_rd_data_o);
        end
        step();
        total++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL sw_done valid=%b busy=%b want 0/0",
                res_valid_o, busy_o);
        end
    endtask

    task automatic test_write_read();
        got_data.delete(); got_err.delete();
        push_cmd(3'd5, 32'hDEADBEEF, 1'b1);
        push_cmd(3'd5, 32'h0, 1'b0);
        wait_results(2);
        total++;
        if (got_data[0] !== 32'h0 || got_err[0] !== 1'b0) begin
            bad++; $display("FAIL wr_first data=%h err=%b want 0/0",
                got_data[0], got_err[0]);
        end
        total++;
        if (got_data[1] !== 32'hDEADBEEF || got_err[1] !== 1'b0) begin
            bad++; $display("FAIL wr_readback data=%h err=%b want deadbeef/0",
                got_data[1], got_err[1]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [5];
        exp[0] = 32'h0;
        exp[1] = 32'h0;
        exp[2] = 32'h11111111;
        exp[3] = 32'h11111111;
        exp[4] = 32'hAAAAAAAA;
        step();
        csr_req_ready_i = 1'b0;
        got_data.delete(); got_err.delete();
        push_cmd(3'd1, 32'h11111111, 1'b1);
        push_cmd(3'd2, 32'h22222222, 1'b1);
        push_cmd(3'd1, 32'h0, 1'b0);
        push_cmd(3'd1, 32'hAAAAAAAA, 1'b1);
        push_cmd(3'd1, 32'h0, 1'b0);
        total++;
        if (cmd_ready_o !== 1'b0 || cmd_count_o !== 3'd4 || csr_req_valid_o !== 1'b1) begin
            bad++; $display("FAIL bp_full ready=%b count=%0d req=%b want 0/4/1",
                cmd_ready_o, cmd_count_o, csr_req_valid_o);
        end
        cmd_addr_i = 3'd7;
        cmd_wr_data_i = 32'h77;
        cmd_wr_en_i = 1'b1;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (csr_req_valid_o !== 1'b1 || csr_addr_o !== 3'd1 ||
                csr_wr_data_o !== 32'h11111111 || csr_wr_en_o !== 1'b1 ||
                cmd_count_o !== 3'd4) begin
                bad++; $display("FAIL bp_stable cyc=%0d addr=%0d data=%h we=%b count=%0d",
                    i, csr_addr_o, csr_wr_data_o, csr_wr_en_o, cmd_count_o);
            end
        end
        cmd_valid_i = 1'b0;
        csr_req_ready_i = 1'b1;
        wait_results(5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_data[i] !== exp[i] || got_err[i] !== 1'b0) begin
                bad++; $display("FAIL bp_order idx=%0d data=%h err=%b want %h/0",
                    i, got_data[i], got_err[i], exp[i]);
            end
        end
        step();
        total++;
        if (busy_o !== 1'b0 || got_data.size() != 5) begin
            bad++; $display("FAIL bp_drop6 busy=%b results=%0d want 0/5",
                busy_o, got_data.size());
        end
    endtask

    task automatic test_timeout();
        auto_rsp = 1'b0;
        res_ready_i = 1'b0;
        push_cmd(3'd3, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        total++;
        if (res_valid_o !== 1'b0) begin
            bad++; $display("FAIL to_early res_valid=%b want 0", res_valid_o);
        end
        step();
        total++;
        if (res_valid_o !== 1'b1 || res_err_o !== 1'b1 || res_rd_data_o !== 32'h0) begin
            bad++; $display("FAIL to_flag valid=%b err=%b data=%h want 1/1/0",
                res_valid_o, res_err_o, res_rd_data_o);
        end
        res_ready_i = 1'b1;
        step();
        total++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL to_done valid=%b busy=%b want 0/0",
                res_valid_o, busy_o);
        end
        stale_req = 1'b1;
        step();
        stale_req = 1'b0;
        total++;
        if (csr_rsp_valid_i !== 1'b1 || csr_rsp_ready_o !== 1'b1) begin
            bad++; $display("FAIL to_stale_hs valid=%b ready=%b want 1/1",
                csr_rsp_valid_i, csr_rsp_ready_o);
        end
        step();
        step();
        total++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || csr_req_valid_o !== 1'b0) begin
            bad++; $display("FAIL to_stale res=%b busy=%b req=%b want 0/0/0",
                res_valid_o, busy_o, csr_req_valid_o);
        end
    endtask

    task automatic test_result_backpressure();
        int n = 0;
        auto_rsp = 1'b1;
        res_ready_i = 1'b0;
        push_cmd(3'd0, 32'h0, 1'b0);
        push_cmd(3'd5, 32'h0, 1'b0);
        while (!res_valid_o && n < 50) begin
            step();
            n++;
        end
        total++;
        if (res_valid_o !== 1'b1) begin
            bad++; $display("FAIL rb_valid got=%b want=1", res_valid_o);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (res_valid_o !== 1'b1 || res_rd_data_o !== 32'h3 || res_err_o !== 1'b0 ||
                csr_req_valid_o !== 1'b0 || cmd_count_o !== 3'd1) begin
                bad++; $display("FAIL rb_hold cyc=%0d valid=%b data=%h req=%b count=%0d",
                    i, res_valid_o, res_rd_data_o, csr_req_valid_o, cmd_count_o);
            end
        end
        got_data.delete(); got_err.delete();
        res_ready_i = 1'b1;
        wait_results(2);
        total++;
        if (got_data[0] !== 32'h3 || got_data[1] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rb_order got=%h,%h want 00000003,deadbeef",
                got_data[0], got_data[1]);
        end
    endtask

    task automatic test_reset_midop();
        int reqs;
        bit seen_req = 1'b0;
        auto_rsp = 1'b0;
        res_ready_i = 1'b1;
        step();
        push_cmd(3'd0, 32'h0, 1'b0);
        push_cmd(3'd1, 32'h0, 1'b0);
        push_cmd(3'd2, 32'h0, 1'b0);
        push_cmd(3'd3, 32'h0, 1'b0);
        total++;
        if (cmd_count_o !== 3'd3 || busy_o !== 1'b1 || csr_req_valid_o !== 1'b0) begin
            bad++; $display("FAIL rm_pre count=%0d busy=%b req=%b want 3/1/0",
                cmd_count_o, busy_o, csr_req_valid_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++;
        if (cmd_count_o !== 3'd0 || busy_o !== 1'b0 || res_valid_o !== 1'b0 ||
            csr_req_valid_o !== 1'b0 || csr_addr_o !== 3'd0 ||
            res_rd_data_o !== 32'h0 || cmd_ready_o !== 1'b1) begin
            bad++; $display("FAIL rm_reset count=%0d busy=%b res=%b req=%b addr=%0d rdy=%b",
                cmd_count_o, busy_o, res_valid_o, csr_req_valid_o, csr_addr_o, cmd_ready_o);
        end
        reqs = req_seen;
        for (int i = 0; i < 20; i++) begin
            step();
            if (csr_req_valid_o !== 1'b0) seen_req = 1'b1;
        end
        total++;
        if (seen_req || req_seen != reqs || busy_o !== 1'b0) begin
            bad++; $display("FAIL rm_quiet req_seen=%b new=%0d busy=%b want 0/0/0",
                seen_req, req_seen - reqs, busy_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 32'h0;
        step();
        test_reset();
        test_single_write();
        test_write_read();
        test_backpressure();
        test_timeout();
        test_result_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
